rle_decoder: RTL

// - Downstream stage of the RLE compressor: expands a compressed frame in the shared dpsram back into plaintext.
// - Reads (count, byte) pairs, two per 32-bit word, from rle_addr; writes expanded bytes, four per word, to msg_addr.
// - Used for round-trip checking of the compressor and as the decompression path of the frame pipeline.

---
 rtl/rle_pkg.sv | 24 ++
 rtl/rle_byte_packer.sv | 35 +++
 rtl/rle_decoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// Shared format definitions for the RLE compressor/decoder pair.
// A compressed word holds two (count, byte) pairs; pair0 sits in the low half.
package rle_pkg;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;

    localparam int unsigned CNT0_LO  = 0;
    localparam int unsigned BYTE0_LO = 8;
    localparam int unsigned CNT1_LO  = 16;
    localparam int unsigned BYTE1_LO = 24;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StExpand,
        StWr,
        StFlush,
        StFin
    } rle_state_t;

endpackage

// File: rtl/rle_byte_packer.sv
// Accumulates decoded bytes little-endian into one 32-bit word; unused bytes read as zero.
module rle_byte_packer
    import rle_pkg::*;
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              clear,
    input  logic              valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              full,
    output logic              nonempty,
    output logic [31:0]       word
);

    logic [2:0]  fill;
    logic [31:0] data;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            data <= '0;
            fill <= '0;
        end else if (clear) begin
            data <= '0;
            fill <= '0;
        end else if (valid) begin
            data[{fill[1:0], 3'b000} +: BYTE_W] <= in_byte;
            fill <= fill + 3'd1;
        end
    end

    assign full     = (fill == 3'(WORD_BYTES));
    assign nonempty = (fill != 3'd0);
    assign word     = data;

endmodule

// File: rtl/rle_decoder.sv
// Expands a (count, byte) compressed frame in dpsram back into plaintext,
// reading two pairs per word and writing four decoded bytes per word.
module rle_decoder
    import rle_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       rle_addr,
    input  logic [31:0]       rle_size,
    input  logic [31:0]       msg_addr,
    output logic [31:0]       msg_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
);

    rle_state_t        state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       pairs_left;
    logic [CNT_W-1:0]  run;
    logic [BYTE_W-1:0] run_byte;
    logic              half;
    logic [CNT_W-1:0]  next_run;
    logic [BYTE_W-1:0] next_byte;

    logic        pk_push;
    logic        pk_clear;
    logic        pk_full;
    logic        pk_nonempty;
    logic [31:0] pk_word;

    logic unused_inputs;
    assign unused_inputs = ^{rle_addr[31:ADDR_W], rle_addr[1:0],
                             msg_addr[31:ADDR_W], msg_addr[1:0], rle_size[0]};

    assign port_A_clk = clk;

    // A full packer is drained before any further byte is accepted.
    assign pk_push  = (state == StExpand) && !pk_full && (run != '0);
    assign pk_clear = ((state == StIdle) && start) || (state == StWr) || (state == StFlush);

    rle_byte_packer u_packer (
        .clk      (clk),
        .nreset   (nreset),
        .clear    (pk_clear),
        .valid    (pk_push),
        .in_byte  (run_byte),
        .full     (pk_full),
        .nonempty (pk_nonempty),
        .word     (pk_word)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state          <= StIdle;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            pairs_left     <= '0;
            run            <= '0;
            run_byte       <= '0;
            half           <= 1'b0;
            next_run       <= '0;
            next_byte      <= '0;
            msg_size       <= '0;
            done           <= 1'b0;
            port_A_addr    <= '0;
            port_A_we      <= 1'b0;
            port_A_data_in <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        rd_ptr     <= {rle_addr[ADDR_W-1:2], 2'b00};
                        wr_ptr     <= {msg_addr[ADDR_W-1:2], 2'b00};
                        pairs_left <= {1'b0, rle_size[31:1]};
                        msg_size   <= '0;
                        done       <= 1'b0;
                        if (rle_size[31:1] == '0) begin
                            state <= StFin;
                        end else begin
                            port_A_addr <= {rle_addr[ADDR_W-1:2], 2'b00};
                            port_A_we   <= 1'b0;
                            state       <= StRdReq;
                        end
                    end
                end
                StRdReq: begin
                    state <= StRdWait;
                end
                StRdWait: begin
                    run        <= port_A_data_out[CNT0_LO +: CNT_W];
                    run_byte   <= port_A_data_out[BYTE0_LO +: BYTE_W];
                    next_run   <= port_A_data_out[CNT1_LO +: CNT_W];
                    next_byte  <= port_A_data_out[BYTE1_LO +: BYTE_W];
                    half       <= 1'b0;
                    pairs_left <= pairs_left - 32'd1;
                    rd_ptr     <= rd_ptr + ADDR_W'(WORD_BYTES);
                    state      <= StExpand;
                end
                StExpand: begin
                    if (pk_full) begin
                        port_A_we      <= 1'b1;
                        port_A_addr    <= wr_ptr;
                        port_A_data_in <= pk_word;
                        state          <= StWr;
                    end else if (run != '0) begin
                        run      <= run - 1'b1;
                        msg_size <= msg_size + 32'd1;
                    end else if (pairs_left == '0) begin
                        if (pk_nonempty) begin
                            port_A_we      <= 1'b1;
                            port_A_addr    <= wr_ptr;
                            port_A_data_in <= pk_word;
                            state          <= StFlush;
                        end else begin
                            state <= StFin;
                        end
                    end else if (!half) begin
                        half       <= 1'b1;
                        run        <= next_run;
                        run_byte   <= next_byte;
                        pairs_left <= pairs_left - 32'd1;
                    end else begin
                        port_A_addr <= rd_ptr;
                        state       <= StRdReq;
                    end
                end
                StWr: begin
                    port_A_we <= 1'b0;
                    wr_ptr    <= wr_ptr + ADDR_W'(WORD_BYTES);
                    state     <= StExpand;
                end
                StFlush: begin
                    port_A_we <= 1'b0;
                    wr_ptr    <= wr_ptr + ADDR_W'(WORD_BYTES);
                    state     <= StFin;
                end
                StFin: begin
                    port_A_we <= 1'b0;
                    done      <= 1'b1;
                    state     <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
